inj_sched: RTL and testbench
============================

Name: inj_sched

Overview:
- Injection scheduler for one NoC router local port. Shares that port between NUM_SRC one-shot pattern buffers, each a 20-bit ROM streamer with an enable input and a registered out_valid.
- Grants the buffers round-robin in slices of SLICE words and gates each buffer's enable against a credit counter for the router input FIFO.
- Muxes the granted buffer's stream onto one registered injection output.
- Flags completion once every buffer has delivered WORDS words.

Parameters:
NUM_SRC, 4, number of pattern buffers served
WORDS, 30, words each buffer emits before it goes permanently idle
SLICE, 6, maximum words per grant before rotating
CREDITS, 4, router input FIFO depth (initial credit count)
DW, 20, flit width

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse, begins a scheduling run (ignored unless IDLE)
credit_ret  input  1  one credit returned by router this cycle
src_valid  input  NUM_SRC  out_valid from each buffer
src_data  input  NUM_SRC*DW  dataout from each buffer; source i at bits [i*DW +: DW]
src_enable  output  NUM_SRC  registered enable to each buffer; at most one bit high
inj_data  output  DW  registered flit to router
inj_valid  output  1  registered flit valid
cur_src  output  clog2(NUM_SRC)  index of current grant
busy  output  1  high from start accepted until DONE
done  output  1  sticky; high in DONE
err  output  1  sticky protocol error

Behaviour:
- Reset (async, rst=0) values:
  - src_enable=0, inj_valid=0, inj_data=0, cur_src=0, busy=0, done=0, err=0.
  - credit_cnt=CREDITS; all per-source remaining counters=WORDS; all armed flags=0; FSM=IDLE.
- Reset mid-run aborts immediately; the buffers themselves are reset by the same rst.
- FSM states: IDLE, ARM, STREAM, DRAIN, DONE.
- IDLE:
  - start -> ARM or STREAM for source 0. ARM is taken if armed[0]=0.
  - busy goes high the cycle after start.
- ARM:
  - src_enable[g]=1 for exactly one cycle; this is the buffer's activation cycle and produces no word.
  - Set armed[g]=1, then go to STREAM.
  - Each source is armed at most once per reset.
- STREAM:
  - Each clock edge with src_enable[g]=1 is one reservation: credit_cnt-1, slice_cnt-1, rem[g]-1.
  - Next-cycle src_enable[g]=1 only if, after this cycle's updates, credit_cnt>0, slice_cnt>0 and rem[g]>0. Otherwise enable drops and the FSM stays in STREAM while credits are the only blocker.
  - When slice_cnt=0 or rem[g]=0: go to DRAIN with enable low.
- DRAIN:
  - Exactly one cycle, so the last reserved word (buffer latency 1) can appear.
  - Then select the next source after g, modulo NUM_SRC, with rem>0. Its slice_cnt loads SLICE, and the FSM goes to ARM or STREAM per its armed flag.
  - If no source has rem>0, go to DONE.
- DONE: done=1, busy=0, src_enable=0. Stays until reset; start is ignored.
- Credits:
  - credit_ret and a reservation in the same cycle leave credit_cnt unchanged.
  - credit_ret when credit_cnt=CREDITS sets err, and credit_cnt saturates.
  - Credits are never negative, by the enable gating above.
- Output mux:
  - Track owner = g registered one cycle.
  - inj_valid <= src_valid[owner]; inj_data <= that source's slice of src_data when valid, else hold.
  - Latency src_valid -> inj_valid is 1 cycle.
  - Any src_valid bit from a source other than owner sets err; that word is dropped.
- cur_src updates on entry to ARM/STREAM.
- Grant rotation wraps from NUM_SRC-1 to 0.

Test Plan:
- Defaults; start at t0; credit_ret pulsed on every inj_valid -> 120 flits total; each grant is 6 words; order src0,1,2,3,0,... for 5 rounds; done=1 after the final DRAIN; err=0.
- Data order -> flits from src 3's first grant are 0x03011..0x03061 in order with no gaps; rem[3]=24 afterward.
- No credit_ret ever -> exactly 4 flits injected, then src_enable stays 0 and busy stays 1 indefinitely.
- Return 1 credit every 3rd cycle -> inj_valid never exceeds 4 outstanding; all 120 flits are delivered in order per source.
- WORDS=7, SLICE=6 -> each source gets grants of 6 then 1; the final rotation skips exhausted sources; done is asserted.
- Force src_valid[2] high while src 0 is granted -> err=1 sticky and no corrupt flit is injected. Separately, credit_ret while credit_cnt=4 -> err=1.
- Assert rst low mid-STREAM -> all outputs are at reset values immediately; a new start reruns from src0 with ARM.

Source files
------------

// File: rtl/inj_sched.sv
// Injection scheduler for one NoC router local port.
// Shares the port round-robin between NUM_SRC one-shot pattern buffers.
// Each buffer's enable is gated against a credit counter for the router input
// FIFO, and the granted buffer's stream is muxed onto one registered output.
`timescale 1ns/1ps
module inj_sched #(
  parameter int NUM_SRC = 4,
  parameter int WORDS   = 30,
  parameter int SLICE   = 6,
  parameter int CREDITS = 4,
  parameter int DW      = 20,
  localparam int SW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  credit_ret,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC*DW-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_enable,
  output logic [DW-1:0]         inj_data,
  output logic                  inj_valid,
  output logic [SW-1:0]         cur_src,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW  = $clog2(CREDITS + 1);
  localparam int SLW = $clog2(SLICE + 1);
  localparam int RW  = $clog2(WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_n;
  logic [SW-1:0]              cur_n;
  logic [CW-1:0]              credit_q, credit_n;
  logic [SLW-1:0]             slice_q, slice_n;
  logic [NUM_SRC-1:0][RW-1:0] rem_q, rem_n;
  logic [NUM_SRC-1:0]         armed_q, armed_n;
  logic [NUM_SRC-1:0]         en_n;
  logic                       busy_n, done_n;
  logic                       res, credit_over;
  logic                       nxt_found;
  logic [SW-1:0]              nxt_g, cand;
  logic [SW-1:0]              owner_q;
  logic [NUM_SRC-1:0]         own_mask;
  logic                       stray;

  // Next-state, credit/slice/remaining bookkeeping and the registered enable.
  // Enable for the next cycle is decided from the post-update counters, so a
  // reservation never drives the credit count below zero.
  always_comb begin
    state_n     = state_q;
    cur_n       = cur_src;
    slice_n     = slice_q;
    rem_n       = rem_q;
    armed_n     = armed_q;
    en_n        = '0;
    busy_n      = busy;
    done_n      = done;
    res         = (state_q == S_STREAM) && src_enable[cur_src];
    credit_over = credit_ret && (credit_q == CW'(CREDITS));
    credit_n    = credit_q;
    if (res && !credit_ret) begin
      credit_n = credit_q - CW'(1);
    end else if (credit_ret && !res && !credit_over) begin
      credit_n = credit_q + CW'(1);
    end
    // round-robin search starting after the current grant, wrapping back to it
    nxt_found = 1'b0;
    nxt_g     = cur_src;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = SW'((32'(cur_src) + i) % NUM_SRC);
      if (!nxt_found && rem_q[cand] != '0) begin
        nxt_found = 1'b1;
        nxt_g     = cand;
      end
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_n   = '0;
          slice_n = SLW'(SLICE);
          busy_n  = 1'b1;
          if (!armed_q[0]) begin
            state_n = S_ARM;
            en_n[0] = 1'b1;
          end else begin
            state_n = S_STREAM;
            en_n[0] = (credit_n != '0);
          end
        end
      end
      S_ARM: begin
        armed_n[cur_src] = 1'b1;
        state_n          = S_STREAM;
        en_n[cur_src]    = (credit_n != '0);
      end
      S_STREAM: begin
        if (res) begin
          slice_n        = slice_q - SLW'(1);
          rem_n[cur_src] = rem_q[cur_src] - RW'(1);
        end
        if (slice_n == '0 || rem_n[cur_src] == '0) begin
          state_n = S_DRAIN;
        end else begin
          en_n[cur_src] = (credit_n != '0);
        end
      end
      S_DRAIN: begin
        if (nxt_found) begin
          cur_n   = nxt_g;
          slice_n = SLW'(SLICE);
          if (!armed_q[nxt_g]) begin
            state_n     = S_ARM;
            en_n[nxt_g] = 1'b1;
          end else begin
            state_n     = S_STREAM;
            en_n[nxt_g] = (credit_n != '0);
          end
        end else begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      src_enable <= '0;
      cur_src    <= '0;
      credit_q   <= CW'(CREDITS);
      slice_q    <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) rem_q[i] <= RW'(WORDS);
      armed_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      src_enable <= en_n;
      cur_src    <= cur_n;
      credit_q   <= credit_n;
      slice_q    <= slice_n;
      rem_q      <= rem_n;
      armed_q    <= armed_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Any valid from a buffer other than the registered owner is a protocol error.
  always_comb begin
    own_mask          = '0;
    own_mask[owner_q] = 1'b1;
    stray             = |(src_valid & ~own_mask);
  end

  // Output mux: owner lags the grant by one cycle to match buffer latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= '0;
      inj_valid <= 1'b0;
      inj_data  <= '0;
      err       <= 1'b0;
    end else begin
      owner_q   <= cur_src;
      inj_valid <= src_valid[owner_q];
      if (src_valid[owner_q]) inj_data <= src_data[owner_q*DW +: DW];
      err       <= err | credit_over | stray;
    end
  end
endmodule

// File: tb/tb_inj_sched.sv
// Bench for inj_sched: one default instance and one with WORDS=7, each fed by
// behavioural one-shot pattern buffers. Expected flit streams come from the
// round-robin/slice rules computed arithmetically.
`timescale 1ns/1ps
module tb_inj_sched;
  localparam int NS = 4;
  localparam int DW = 20;
  localparam int SL = 6;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cr = 1'b0;
  logic sel = 1'b0;
  logic [NS-1:0] stray = '0;

  logic            start_a, start_b, cr_a, cr_b;
  logic [NS-1:0]   sv_a, sv_b, en_a, en_b;
  logic [NS*DW-1:0] sd_a, sd_b;
  logic [DW-1:0]   id_a, id_b;
  logic            iv_a, iv_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [1:0]      cs_a, cs_b;

  logic [1:0][NS-1:0]      en_all, act, bv;
  logic [1:0][NS-1:0][7:0] ptr;
  logic [1:0][NS*DW-1:0]   bd;

  logic [NS-1:0] o_en;
  logic [DW-1:0] o_data;
  logic          o_valid, o_busy, o_done, o_err;
  logic [1:0]    o_cur;

  int total = 0;
  int bad = 0;

  typedef struct {
    int cfg;       // 0: defaults, 1: WORDS=7
    int mode;      // 0 none, 1 every flit, 2 every 3rd cycle, 3 random
    int budget;
    bit stray_on;
    int flits;
    bit done_e;
    bit busy_e;
    bit err_e;
  } vec_t;

  vec_t vecs[7];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign cr_a    = cr & ~sel;
  assign cr_b    = cr & sel;
  assign sv_a    = bv[0] | stray;
  assign sd_a    = bd[0];
  assign sv_b    = bv[1];
  assign sd_b    = bd[1];
  assign en_all  = {en_b, en_a};

  inj_sched dut (
    .clk(clk), .rst(rst), .start(start_a), .credit_ret(cr_a),
    .src_valid(sv_a), .src_data(sd_a), .src_enable(en_a),
    .inj_data(id_a), .inj_valid(iv_a), .cur_src(cs_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  inj_sched #(.WORDS(7)) dut7 (
    .clk(clk), .rst(rst), .start(start_b), .credit_ret(cr_b),
    .src_valid(sv_b), .src_data(sd_b), .src_enable(en_b),
    .inj_data(id_b), .inj_valid(iv_b), .cur_src(cs_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  always_comb begin
    o_en    = sel ? en_b   : en_a;
    o_data  = sel ? id_b   : id_a;
    o_valid = sel ? iv_b   : iv_a;
    o_busy  = sel ? busy_b : busy_a;
    o_done  = sel ? done_b : done_a;
    o_err   = sel ? err_b  : err_a;
    o_cur   = sel ? cs_b   : cs_a;
  end

  function automatic logic [DW-1:0] mkword(input int s, input int k);
    logic [7:0] hs, hk;
    hs = s[7:0];
    hk = k[7:0];
    return {hs, hk, 4'h1};
  endfunction

  // Pattern buffers: first enable edge activates, each later one emits a word.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      act <= '0;
      bv  <= '0;
      bd  <= '0;
      ptr <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int s = 0; s < NS; s++) begin
          if (en_all[c][s]) begin
            if (!act[c][s]) begin
              act[c][s] <= 1'b1;
              bv[c][s]  <= 1'b0;
            end else begin
              bv[c][s]            <= 1'b1;
              bd[c][s*DW +: DW]   <= mkword(s, int'(ptr[c][s]) + 1);
              ptr[c][s]           <= ptr[c][s] + 8'd1;
            end
          end else begin
            bv[c][s] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Expected stream: rounds of up to SL words per source, exhausted ones skipped.
  task automatic build_exp(input int words);
    int hi;
    exp_q.delete();
    for (int r = 0; r * SL < words; r++) begin
      for (int s = 0; s < NS; s++) begin
        hi = ((r + 1) * SL < words) ? (r + 1) * SL : words;
        for (int k = r * SL + 1; k <= hi; k++) exp_q.push_back(mkword(s, k));
      end
    end
  endtask

  task automatic do_reset(input logic which);
    sel = which; stray = '0; cr = 1'b0; start = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_case(input int id, input vec_t v);
    int outst, maxo, got;
    logic [DW-1:0] e;
    do_reset(v.cfg[0]);
    build_exp(v.cfg == 1 ? 7 : 30);
    got_q.delete();
    pulse_start();
    outst = 0; maxo = 0; got = 0;
    for (int cyc = 0; cyc < v.budget; cyc++) begin
      @(posedge clk); #1;
      cr = 1'b0;
      stray = '0;
      chk("enable_onehot0", 32'($onehot0(o_en)), 1);
      if (o_valid) begin
        got++;
        outst++;
        got_q.push_back(o_data);
        chk("flit_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("flit_data", o_data, e);
        end
      end
      if (outst > maxo) maxo = outst;
      case (v.mode)
        1: cr = o_valid;
        2: cr = (cyc % 3 == 2) && (outst > 0);
        3: cr = (outst > 0) && ($urandom_range(0, 1) == 1);
        default: cr = 1'b0;
      endcase
      if (cr) outst--;
      if (v.stray_on && cyc == 3) begin
        chk("stray_while_src0", o_cur, 0);
        stray = 4'b0100;
      end
      if (o_done) break;
    end
    cr = 1'b0;
    stray = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_extra_flit", o_valid, 0);
    end
    chk("flit_count", got, v.flits);
    chk("done", o_done, v.done_e);
    chk("busy", o_busy, v.busy_e);
    chk("err", o_err, v.err_e);
    chk("enable_idle", o_en, 0);
    chk("outstanding_bound", 32'(maxo <= CR), 1);
    if (id == 0) begin
      chk("src3_first_word", got_q[18], 20'h03011);
      chk("src3_last_word", got_q[23], 20'h03061);
      chk("src3_second_grant", got_q[42], 20'h03071);
    end
    if (id == 5) begin
      chk("w7_src0_tail", got_q[24], 20'h00071);
      chk("w7_src3_tail", got_q[27], 20'h03071);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1, 2000, 1'b0, 120, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{0, 0,  200, 1'b0,   4, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{0, 2, 3000, 1'b0, 120, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{0, 3, 3000, 1'b0, 120, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{0, 1, 2000, 1'b1, 120, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1, 1, 1000, 1'b0,  28, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1, 3, 1000, 1'b0,  28, 1'b1, 1'b0, 1'b0};

    // reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_enable", en_a, 0);
    chk("rst_inj_valid", iv_a, 0);
    chk("rst_inj_data", id_a, 0);
    chk("rst_cur_src", cs_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk); rst = 1'b1;

    // first start: one activation cycle, then streaming; first flit 3 edges on
    pulse_start();
    chk("arm_busy", busy_a, 1);
    chk("arm_enable", en_a, 4'b0001);
    chk("arm_cur_src", cs_a, 0);
    @(posedge clk); #1;
    chk("stream_enable", en_a, 4'b0001);
    chk("arm_no_word", iv_a, 0);
    @(posedge clk); #1;
    chk("first_word_pending", iv_a, 0);
    @(posedge clk); #1;
    chk("first_word_valid", iv_a, 1);
    chk("first_word_data", id_a, 20'h00011);

    // credit return with a full counter is an error, and it sticks
    do_reset(1'b0);
    @(posedge clk); #1 cr = 1'b1;
    @(posedge clk); #1 cr = 1'b0;
    chk("credit_over_err", err_a, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("credit_over_sticky", err_a, 1);

    // asynchronous reset mid-stream, then a clean rerun starting with ARM
    do_reset(1'b0);
    pulse_start();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      cr = iv_a;
    end
    cr = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_enable", en_a, 0);
    chk("midrst_inj_valid", iv_a, 0);
    chk("midrst_inj_data", id_a, 0);
    chk("midrst_cur_src", cs_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_err", err_a, 0);
    @(negedge clk); rst = 1'b1;
    pulse_start();
    chk("rerun_arm_enable", en_a, 4'b0001);
    chk("rerun_cur_src", cs_a, 0);
    chk("rerun_busy", busy_a, 1);

    for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
